// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters / RAM (master side) and mem_arbiter (slave side).
//   req0_*      port 0 (CPU) command, address, write data and ready pulse
//   req1_*      port 1 (loader/debug) command, address, write data and ready pulse
//   rdata       read data of the last completed read, shared by both ports
//   mem_*       RAM command, address, write data and read data
//   owner/busy  arbitration status
// Command encoding everywhere: 00 none, 01 read, 10 write, 11 treated as none.
interface mem_arbiter_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) ();
  logic [1:0]    req0_cmd;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_ready;
  logic [1:0]    req1_cmd;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_ready;
  logic [DW-1:0] rdata;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          owner;
  logic          busy;

  // Requesters and RAM.
  modport master (
    output req0_cmd, req0_addr, req0_wdata,
    output req1_cmd, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req1_ready, rdata, mem_cmd, mem_addr, mem_wdata, owner, busy
  );

  // Arbiter.
  modport slave (
    input  req0_cmd, req0_addr, req0_wdata,
    input  req1_cmd, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req1_ready, rdata, mem_cmd, mem_addr, mem_wdata, owner, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AW x DW RAM between port 0 (CPU) and port 1 (loader/debug).
// Each access runs IDLE -> ACCESS (WAIT cycles) -> DONE (one-cycle ready pulse) -> IDLE.
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_reset  synchronous active-high reset; aborts any access without a ready pulse
//   bus      mem_arbiter_if.slave: requester commands in, ready/rdata out, RAM bus, owner/busy
// Parameters: AW address width, DW data width, WAIT access cycles per transfer (1..15).
// Build option: define MEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 always
// wins ties and port 1 can starve under continuous port 0 traffic.
module mem_arbiter #(
  parameter int unsigned AW   = 9,
  parameter int unsigned DW   = 16,
  parameter int unsigned WAIT = 2
) (
  input logic          i_clk,
  input logic          i_reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic [1:0] CmdNone  = 2'b00;
  localparam logic [1:0] CmdRead  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;

  localparam logic [3:0] WaitLast = 4'(WAIT - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [1:0]    r_cmd;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_owner;

  logic          w_req0;
  logic          w_req1;
  logic          w_grant_port;

  // 11 is not a request.
  assign w_req0 = (bus.req0_cmd == CmdRead) || (bus.req0_cmd == CmdWrite);
  assign w_req1 = (bus.req1_cmd == CmdRead) || (bus.req1_cmd == CmdWrite);

`ifdef MEM_ARB_RR_EN
  logic r_rr_last;
  // Tie goes to the port not granted on the previous tie.
  assign w_grant_port = (w_req0 && w_req1) ? ~r_rr_last : w_req1;
`else
  assign w_grant_port = w_req1 && !w_req0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_cmd   <= CmdNone;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_owner <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_rr_last <= 1'b1;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req0 || w_req1) begin
            r_owner <= w_grant_port;
            r_cmd   <= w_grant_port ? bus.req1_cmd   : bus.req0_cmd;
            r_addr  <= w_grant_port ? bus.req1_addr  : bus.req0_addr;
            r_wdata <= w_grant_port ? bus.req1_wdata : bus.req0_wdata;
            r_cnt   <= WaitLast;
            r_state <= StAccess;
`ifdef MEM_ARB_RR_EN
            if (w_req0 && w_req1) begin
              r_rr_last <= w_grant_port;
            end
`endif
          end
        end
        StAccess: begin
          if (r_cnt == 4'd0) begin
            // RAM read data is valid in the final access cycle.
            if (r_cmd == CmdRead) begin
              r_rdata <= bus.mem_rdata;
            end
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.mem_cmd    = (r_state == StAccess) ? r_cmd : CmdNone;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.rdata      = r_rdata;
  assign bus.owner      = r_owner;
  assign bus.busy       = (r_state != StIdle);
  assign bus.req0_ready = (r_state == StDone) && !r_owner;
  assign bus.req1_ready = (r_state == StDone) && r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int WAIT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  // RAM device seen by the DUT.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk) if (bus.mem_cmd == 2'b10) ram[bus.mem_addr] <= bus.mem_wdata;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  // A grant at cycle g occupies the RAM in cycles g+1..g+WAIT, pulses ready in g+WAIT+1,
  // and the next request can be sampled in cycle g+WAIT+2.
  int            cyc = 0;
  bit            started = 0;
  bit            t_v = 0;
  int            t_g;
  logic          t_port;
  logic [1:0]    t_cmd;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  int            free_at = 0;
  logic          m_owner = 0;
  logic [DW-1:0] m_rdata = 0;
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
`ifdef MEM_ARB_RR_EN
  logic          m_rr = 1;
`endif

  always @(posedge clk) begin
    bit r0, r1, p;
    r0 = (bus.req0_cmd == 2'b01) || (bus.req0_cmd == 2'b10);
    r1 = (bus.req1_cmd == 2'b01) || (bus.req1_cmd == 2'b10);
    if (reset) begin
      t_v = 0; free_at = 0; m_owner = 0; m_rdata = 0;
`ifdef MEM_ARB_RR_EN
      m_rr = 1;
`endif
    end else begin
      if (t_v && cyc == t_g + WAIT) begin
        if (t_cmd == 2'b01) m_rdata = m_mem[t_addr];
        else m_mem[t_addr] = t_wdata;
      end
      if (cyc >= free_at && (r0 || r1)) begin
        if (r0 && r1) begin
`ifdef MEM_ARB_RR_EN
          p = ~m_rr;
          m_rr = p;
`else
          p = 0;
`endif
        end else begin
          p = r1;
        end
        t_v = 1; t_g = cyc; t_port = p;
        t_cmd   = p ? bus.req1_cmd   : bus.req0_cmd;
        t_addr  = p ? bus.req1_addr  : bus.req0_addr;
        t_wdata = p ? bus.req1_wdata : bus.req0_wdata;
        m_owner = p;
        free_at = cyc + WAIT + 2;
      end
    end
    cyc++;
    started = 1;
  end

  always @(negedge clk) begin
    bit act, dn;
    if (started) begin
      act = t_v && (cyc >= t_g + 1) && (cyc <= t_g + WAIT);
      dn  = t_v && (cyc == t_g + WAIT + 1);
      chk("m_mem_cmd", 32'(bus.mem_cmd), act ? 32'(t_cmd) : 32'd0);
      chk("m_busy", 32'(bus.busy), 32'(act || dn));
      chk("m_ready0", 32'(bus.req0_ready), 32'(dn && !t_port));
      chk("m_ready1", 32'(bus.req1_ready), 32'(dn && t_port));
      chk("m_owner", 32'(bus.owner), 32'(m_owner));
      chk("m_rdata", 32'(bus.rdata), 32'(m_rdata));
      if (act) begin
        chk("m_mem_addr", 32'(bus.mem_addr), 32'(t_addr));
        if (t_cmd == 2'b10) chk("m_mem_wdata", 32'(bus.mem_wdata), 32'(t_wdata));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit port, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (port ? bus.req1_ready : bus.req0_ready) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.busy; i++) tick();
    chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit ok;
    int n, c0, c1;
    int order [4];
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      m_mem[i] = '0;
    end
    ram[5] = 16'hBEEF;
    m_mem[5] = 16'hBEEF;
    bus.req0_cmd = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
    bus.req1_cmd = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
    reset = 1;
    tick(); tick();
    chk("rst_mem_cmd", 32'(bus.mem_cmd), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);

    // 1: port 0 read of 0x005, ready in cycle 3.
    reset = 0;
    bus.req0_cmd = 2'b01; bus.req0_addr = 9'h005;
    tick();
    chk("t1_cmd_c1", 32'(bus.mem_cmd), 32'd1);
    chk("t1_addr_c1", 32'(bus.mem_addr), 32'h005);
    chk("t1_rdy_c1", 32'(bus.req0_ready), 32'd0);
    tick();
    chk("t1_cmd_c2", 32'(bus.mem_cmd), 32'd1);
    chk("t1_addr_c2", 32'(bus.mem_addr), 32'h005);
    tick();
    chk("t1_rdy_c3", 32'(bus.req0_ready), 32'd1);
    chk("t1_rdata", 32'(bus.rdata), 32'hBEEF);
    chk("t1_cmd_c3", 32'(bus.mem_cmd), 32'd0);
    bus.req0_cmd = 2'b00;
    tick();
    chk("t1_rdy_c4", 32'(bus.req0_ready), 32'd0);

    // 2: port 1 write 0x1FF <- 0x1234, then read it back.
    bus.req1_cmd = 2'b10; bus.req1_addr = 9'h1FF; bus.req1_wdata = 16'h1234;
    wait_ready(1, ok);
    chk("t2_ready", 32'(ok), 32'd1);
    chk("t2_rdata_kept", 32'(bus.rdata), 32'hBEEF);
    bus.req1_cmd = 2'b00;
    tick();
    bus.req0_cmd = 2'b01; bus.req0_addr = 9'h1FF;
    wait_ready(0, ok);
    chk("t2_rd_ready", 32'(ok), 32'd1);
    chk("t2_readback", 32'(bus.rdata), 32'h1234);
    bus.req0_cmd = 2'b00;
    tick();

    // 3: simultaneous reads after reset: port 0 then port 1, one pulse each.
    reset = 1; tick(); reset = 0;
    bus.req0_cmd = 2'b01; bus.req0_addr = 9'h005;
    bus.req1_cmd = 2'b01; bus.req1_addr = 9'h1FF;
    n = 0; c0 = 0; c1 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.req0_ready) begin
        if (n < 4) order[n] = 0;
        n++; c0++; bus.req0_cmd = 2'b00;
      end
      if (bus.req1_ready) begin
        if (n < 4) order[n] = 1;
        n++; c1++; bus.req1_cmd = 2'b00;
      end
    end
    chk("t3_count", 32'(n), 32'd2);
    chk("t3_first", 32'(order[0]), 32'd0);
    chk("t3_second", 32'(order[1]), 32'd1);
    chk("t3_pulses0", 32'(c0), 32'd1);
    chk("t3_pulses1", 32'(c1), 32'd1);
    chk("t3_rdata", 32'(bus.rdata), 32'h1234);

    // 4: both ports requesting continuously for 4 accesses.
    reset = 1; tick(); reset = 0;
    bus.req0_cmd = 2'b01; bus.req0_addr = 9'h005;
    bus.req1_cmd = 2'b01; bus.req1_addr = 9'h1FF;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (bus.req0_ready) begin order[n] = 0; n++; end
      else if (bus.req1_ready) begin order[n] = 1; n++; end
    end
    bus.req0_cmd = 2'b00; bus.req1_cmd = 2'b00;
    chk("t4_count", 32'(n), 32'd4);
`ifdef MEM_ARB_RR_EN
    chk("t4_g0", 32'(order[0]), 32'd0);
    chk("t4_g1", 32'(order[1]), 32'd1);
    chk("t4_g2", 32'(order[2]), 32'd0);
    chk("t4_g3", 32'(order[3]), 32'd1);
`else
    chk("t4_g0", 32'(order[0]), 32'd0);
    chk("t4_g1", 32'(order[1]), 32'd0);
    chk("t4_g2", 32'(order[2]), 32'd0);
    chk("t4_g3", 32'(order[3]), 32'd0);
`endif
    tick();
    wait_idle();

    // 5: reset during a port 1 read access.
    bus.req1_cmd = 2'b01; bus.req1_addr = 9'h005;
    tick();
    chk("t5_in_access", 32'(bus.mem_cmd), 32'd1);
    reset = 1; bus.req1_cmd = 2'b00;
    tick();
    chk("t5_mem_cmd", 32'(bus.mem_cmd), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_rdata", 32'(bus.rdata), 32'd0);
    chk("t5_ready1", 32'(bus.req1_ready), 32'd0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_ready", 32'(bus.req1_ready), 32'd0);
    end

    // 6: cmd 11 is not a request.
    bus.req0_cmd = 2'b11; bus.req0_addr = 9'h005;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_mem_cmd", 32'(bus.mem_cmd), 32'd0);
      chk("t6_busy", 32'(bus.busy), 32'd0);
    end
    bus.req0_cmd = 2'b00;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
